shift_add_mult: RTL and testbench
=================================

Name: shift_add_mult

Overview:
Sequential unsigned multiplier built on the ripple-carry adder. It takes two WIDTH-bit operands and iterates shift-and-add once per cycle through a single RCA instance (SIZE = WIDTH). It produces a 2*WIDTH-bit product. It sits downstream of the adder in the ALU datapath, consumes the RCA's WIDTH+1-bit sum each cycle, and presents the product to the ALU result mux through a valid/ready handshake.

Parameters:
WIDTH, 8, operand width in bits; legal range 1 to 32.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start_valid  input  1  operands a/b are valid
start_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  multiplicand (unsigned)
b  input  WIDTH  multiplier (unsigned)
result_valid  output  1  product is valid; high only in DONE
result_ready  input  1  consumer accepts product
product  output  2*WIDTH  a*b, unsigned
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low at a clk edge): state = IDLE; A, Q, M, count = 0; product = 0; result_valid = 0; busy = 0; start_ready = 1 from the first cycle after reset. Reset overrides every other event, including mid-RUN and mid-DONE; any in-flight operation is discarded with no result.
- Internal registers:
  - A: WIDTH bits, high accumulator
  - Q: WIDTH bits, multiplier / low product
  - M: WIDTH bits, multiplicand
  - count: max(1, $clog2(WIDTH)) bits
- RCA instance: inputs A and M; output sum is WIDTH+1 bits.
- IDLE:
  - start_ready = 1.
  - On start_valid && start_ready: M <= a, Q <= b, A <= 0, count <= 0, state <= RUN.
  - Otherwise hold.
- RUN (one iteration per cycle):
  - If Q[0] = 1: {A,Q} <= {sum, Q} >> 1, so that A <= sum[WIDTH:1] and Q <= {sum[0], Q[WIDTH-1:1]}.
  - If Q[0] = 0: {A,Q} <= {1'b0, A, Q} >> 1.
  - count <= count + 1.
  - When count == WIDTH-1 at the edge, state <= DONE.
- DONE:
  - result_valid = 1 and product = {A,Q}.
  - product and result_valid stay stable until result_ready is high at an edge; then state <= IDLE.
- Latency: operands accepted at edge k produce result_valid high after edge k+WIDTH. Minimum issue interval is WIDTH+2 cycles (RUN WIDTH cycles, DONE 1 cycle, IDLE 1 cycle).
- start_valid while busy: ignored. start_ready is low; no operand capture; a and b are don't-care.
- DONE with result_ready and start_valid both high: only the handoff happens. A new start is accepted no earlier than the following cycle, in IDLE.
- No overflow is possible: the full 2*WIDTH-bit product is always exact. The adder carry-out is consumed in the shift, never dropped.
- product outside DONE holds its last value, or 0 after reset. Consumers qualify it with result_valid only.
- Operands are unsigned only. Signed support is out of scope.

Decomposition:
- Shared package alu_pkg holds:
  - typedef enum logic [1:0] mult_state_e {MULT_IDLE, MULT_RUN, MULT_DONE}
  - localparam MULT_MAX_WIDTH = 32
- One sub-module: the existing RCA, instantiated once with SIZE = WIDTH. No new sub-modules.
- FSM, counter and shift register live in shift_add_mult itself.

Test Plan:
1. WIDTH=8, a=13, b=11, result_ready held high -> result_valid after exactly 8 cycles, product=16'h008F, start_ready high the cycle after the handoff.
2. WIDTH=8, a=255, b=255 -> product=16'hFE01, exercising the RCA carry-out on every iteration. Also a=0, b=200 -> product=0. Also a=200, b=0 -> product=0.
3. Backpressure: a=7, b=9, result_ready low for 5 cycles after result_valid rises -> product=16'h003F held stable, result_valid stays high, returns to IDLE only on the cycle result_ready=1.
4. Busy rejection: a second start_valid with a=1, b=1 pulsed during RUN and during DONE -> not captured; first result unchanged; start_ready low throughout.
5. Reset mid-operation: rst_n low for 1 cycle at RUN iteration 4 -> next cycle state IDLE, result_valid=0, product=0, start_ready=1; the next op a=3, b=5 yields 16'h000F.
6. Random plus corners at WIDTH=1 and WIDTH=16:
   - WIDTH=1, a=1, b=1 -> product=2'b01 after 1 cycle.
   - WIDTH=16, 1000 random pairs compared against a*b, with random result_ready gaps.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: multiplier FSM states and width limits.
package alu_pkg;

    typedef enum logic [1:0] {
        MULT_IDLE,
        MULT_RUN,
        MULT_DONE
    } mult_state_e;

    localparam int MULT_MAX_WIDTH = 32;

endpackage

// File: rtl/rca.sv
// Ripple-carry adder: SIZE-bit operands, SIZE+1-bit sum with the carry-out on top.
module rca #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic [SIZE:0]   sum
);

    logic [SIZE:0] carry;

    assign carry[0] = 1'b0;

    for (genvar gi = 0; gi < SIZE; gi++) begin : g_fa
        assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
        assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end

    assign sum[SIZE] = carry[SIZE];

endmodule

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one RCA iteration per cycle,
// 2*WIDTH-bit product delivered through a valid/ready handshake.
module shift_add_mult
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    mult_state_e          state_reg, state_next;
    logic [WIDTH-1:0]     acc_reg, acc_next;
    logic [WIDTH-1:0]     q_reg, q_next;
    logic [WIDTH-1:0]     m_reg, m_next;
    logic [CNT_W-1:0]     count_reg, count_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH:0]     shift_in;
    logic [2*WIDTH-1:0]   shifted;

    rca #(.SIZE(WIDTH)) u_rca (
        .a   (acc_reg),
        .b   (m_reg),
        .sum (sum)
    );

    // The carry-out rides into the top of the shift, so the product stays exact.
    assign shift_in = q_reg[0] ? {sum, q_reg} : {1'b0, acc_reg, q_reg};
    assign shifted  = shift_in[2*WIDTH:1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= MULT_IDLE;
            acc_reg     <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            count_reg   <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            q_reg       <= q_next;
            m_reg       <= m_next;
            count_reg   <= count_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        q_next       = q_reg;
        m_next       = m_reg;
        count_next   = count_reg;
        product_next = product_reg;
        case (state_reg)
            MULT_IDLE: begin
                if (start_valid) begin
                    m_next     = a;
                    q_next     = b;
                    acc_next   = '0;
                    count_next = '0;
                    state_next = MULT_RUN;
                end
            end
            MULT_RUN: begin
                {acc_next, q_next} = shifted;
                count_next         = count_reg + 1'b1;
                if (count_reg == LAST_COUNT) begin
                    product_next = shifted;
                    state_next   = MULT_DONE;
                end
            end
            MULT_DONE: begin
                if (result_ready) begin
                    state_next = MULT_IDLE;
                end
            end
            default: state_next = MULT_IDLE;
        endcase
    end

    assign start_ready  = (state_reg == MULT_IDLE);
    assign result_valid = (state_reg == MULT_DONE);
    assign busy         = (state_reg == MULT_RUN) || (state_reg == MULT_DONE);
    assign product      = product_reg;

endmodule

// File: tb/tb_shift_add_mult.sv
// Self-checking bench for shift_add_mult at WIDTH = 8, 1 and 16 against a plain a*b model.
module tb_shift_add_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        sv8, sr8, rv8, rr8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    logic        sv1, sr1, rv1, rr1, busy1;
    logic [0:0]  a1, b1;
    logic [1:0]  p1;

    logic        sv16, sr16, rv16, rr16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    shift_add_mult #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
        .a(a8), .b(b8), .result_valid(rv8), .result_ready(rr8),
        .product(p8), .busy(busy8)
    );

    shift_add_mult #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
        .a(a1), .b(b1), .result_valid(rv1), .result_ready(rr1),
        .product(p1), .busy(busy1)
    );

    shift_add_mult #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_valid(sv16), .start_ready(sr16),
        .a(a16), .b(b16), .result_valid(rv16), .result_ready(rr16),
        .product(p16), .busy(busy16)
    );

    int test_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_cnt++;
        assert (obs === exp) else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 transaction; poke fires a rejected start during RUN and DONE.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input int gap, input bit poke);
        logic [15:0] exp;
        int cyc;
        exp = {8'b0, ta} * {8'b0, tb_v};
        rr8 = (gap == 0);
        a8 = ta; b8 = tb_v; sv8 = 1'b1;
        check("start_ready8_idle", sr8, 1);
        step();
        sv8 = 1'b0;
        cyc = 0;
        while (!rv8 && cyc < 40) begin
            if (poke && cyc == 3) begin
                sv8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
            end
            step();
            cyc++;
            if (poke && cyc == 4) begin
                check("start_ready8_run", sr8, 0);
                sv8 = 1'b0;
            end
        end
        check("latency8", cyc, 8);
        check("product8", p8, exp);
        check("busy8_done", busy8, 1);
        if (poke) begin
            sv8 = 1'b1; a8 = 8'd1; b8 = 8'd1;
        end
        for (int i = 0; i < gap; i++) begin
            step();
            check("hold_valid8", rv8, 1);
            check("hold_product8", p8, exp);
            check("start_ready8_done", sr8, 0);
        end
        rr8 = 1'b1;
        step();
        check("handoff_valid8", rv8, 0);
        check("handoff_idle8", sr8, 1);
        if (poke) check("handoff_no_capture8", busy8, 0);
        sv8 = 1'b0;
        rr8 = 1'b0;
        $display("[TB] w8 a=%0d b=%0d gap=%0d product=%0h expect=%0h latency=%0d", ta, tb_v, gap, p8, exp, cyc);
    endtask

    task automatic run1(input logic [0:0] ta, input logic [0:0] tb_v);
        logic [1:0] exp;
        int cyc;
        exp = {1'b0, ta} * {1'b0, tb_v};
        rr1 = 1'b1;
        a1 = ta; b1 = tb_v; sv1 = 1'b1;
        step();
        sv1 = 1'b0;
        cyc = 0;
        while (!rv1 && cyc < 20) begin
            step();
            cyc++;
        end
        check("latency1", cyc, 1);
        check("product1", p1, exp);
        step();
        check("handoff_idle1", sr1, 1);
        rr1 = 1'b0;
        $display("[TB] w1 a=%0d b=%0d product=%0h expect=%0h latency=%0d", ta, tb_v, p1, exp, cyc);
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_v, input int gap);
        logic [31:0] exp;
        int cyc;
        exp = {16'b0, ta} * {16'b0, tb_v};
        rr16 = (gap == 0);
        a16 = ta; b16 = tb_v; sv16 = 1'b1;
        step();
        sv16 = 1'b0;
        cyc = 0;
        while (!rv16 && cyc < 60) begin
            step();
            cyc++;
        end
        check("latency16", cyc, 16);
        check("product16", p16, exp);
        if (gap > 0) begin
            repeat (gap) step();
            check("hold_valid16", rv16, 1);
            check("hold_product16", p16, exp);
        end
        rr16 = 1'b1;
        step();
        check("handoff_idle16", sr16, 1);
        rr16 = 1'b0;
        $display("[TB] w16 a=%0d b=%0d gap=%0d product=%0h expect=%0h latency=%0d", ta, tb_v, gap, p16, exp, cyc);
    endtask

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        rst_n = 1'b0;
        sv8 = 1'b0; rr8 = 1'b0; a8 = '0; b8 = '0;
        sv1 = 1'b0; rr1 = 1'b0; a1 = '0; b1 = '0;
        sv16 = 1'b0; rr16 = 1'b0; a16 = '0; b16 = '0;

        step();
        step();
        check("reset_start_ready8", sr8, 1);
        check("reset_valid8", rv8, 0);
        check("reset_busy8", busy8, 0);
        check("reset_product8", p8, 0);
        rst_n = 1'b1;
        step();

        run8(8'd13, 8'd11, 0, 1'b0);
        run8(8'd255, 8'd255, 0, 1'b0);
        run8(8'd0, 8'd200, 0, 1'b0);
        run8(8'd200, 8'd0, 0, 1'b0);
        run8(8'd7, 8'd9, 5, 1'b0);
        run8(8'd100, 8'd77, 2, 1'b1);
        run8(8'd45, 8'd6, 0, 1'b1);

        a8 = 8'd200; b8 = 8'd100; sv8 = 1'b1;
        step();
        sv8 = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("midrun_reset_ready8", sr8, 1);
        check("midrun_reset_valid8", rv8, 0);
        check("midrun_reset_product8", p8, 0);
        check("midrun_reset_busy8", busy8, 0);
        repeat (12) step();
        check("midrun_no_result8", rv8, 0);
        $display("[TB] w8 reset mid-run ready=%0d valid=%0d product=%0h", sr8, rv8, p8);
        run8(8'd3, 8'd5, 0, 1'b0);

        run1(1'b1, 1'b1);
        run1(1'b1, 1'b0);
        run1(1'b0, 1'b1);

        for (int n = 0; n < 1000; n++) begin
            if (n == 0) begin
                ra = 16'hFFFF; rb = 16'hFFFF;
            end else if (n == 1) begin
                ra = 16'h0000; rb = 16'hBEEF;
            end else begin
                ra = 16'($urandom);
                rb = 16'($urandom);
            end
            run16(ra, rb, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
